handshake_arbiter: RTL and testbench
====================================

HANDSHAKE_ARBITER -- requirements
Module: handshake_arbiter

Interface
REQ-001 Parameter: REQ_NUM, default 4, number of requesters sharing one handshake channel; legal range 2..16.
REQ-002 Derived width: IW = $clog2(REQ_NUM).
REQ-003 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req_req  input  REQ_NUM  per-requester request; bit i = requester i.
REQ-006 Port: req_rdy  output  REQ_NUM  per-requester ready; transfer of requester i occurs when req_req[i] & req_rdy[i].
REQ-007 Port: ch_req  output  1  request to the shared channel (source side of a handshake synchronizer).
REQ-008 Port: ch_rdy  input  1  ready from the shared channel; transfer occurs when ch_req & ch_rdy.
REQ-009 Port: sel_idx  output  IW  index of the granted requester, for steering payload muxes.
REQ-010 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 FSM states: IDLE, GRANT, WAIT; exactly one active.
REQ-012 Registered state: FSM state, grant index gnt (IW bits), round-robin pointer ptr (IW bits).
REQ-013 IDLE: ch_req=0, req_rdy=0; if req_req != 0 and ch_rdy=1, load gnt with the winner and go to GRANT; else stay.
REQ-014 Winner: first index i with req_req[i]=1, searching ptr, ptr+1, ..., REQ_NUM-1, 0, ..., ptr-1 (wrap mod REQ_NUM).
REQ-015 GRANT: ch_req = req_req[gnt] (combinational); req_rdy[gnt] = ch_rdy; all other req_rdy bits 0.
REQ-016 GRANT, transfer (req_req[gnt] & ch_rdy): go to WAIT, ptr <= (gnt+1) mod REQ_NUM.
REQ-017 GRANT, req_req[gnt]=0 (requester withdrew): go to IDLE without transfer; ptr unchanged.
REQ-018 GRANT, req_req[gnt]=1 and ch_rdy=0: stay in GRANT, hold gnt.
REQ-019 WAIT: ch_req=0, req_rdy=0; go to IDLE on the first cycle with ch_rdy=1; stay while ch_rdy=0.
REQ-020 sel_idx = gnt at all times; gnt changes only on IDLE->GRANT.
REQ-021 At most one transfer per GRANT visit; at most one req_rdy bit high in any cycle.
REQ-022 Latency: request seen in IDLE at cycle n -> ch_req and req_rdy[gnt] high at cycle n+1 (if ch_rdy=1 and request held); min spacing between consecutive transfers is 3 cycles (GRANT, WAIT, IDLE).
REQ-023 Requests from non-granted requesters during GRANT/WAIT are ignored and arbitrated only on the next IDLE.
REQ-024 Pointer wrap: gnt = REQ_NUM-1 transfer -> ptr = 0.
REQ-025 No starvation: a continuously held request is granted within REQ_NUM transfers.

Reset
REQ-026 While reset=1 at a clock edge: state <= IDLE, gnt <= 0, ptr <= 0.
REQ-027 Output values during and after reset until the next request: ch_req=0, req_rdy=0, busy=0, sel_idx=0.
REQ-028 Reset asserted in GRANT or WAIT abandons the operation with no transfer on the reset cycle's outputs after the edge; the channel's own reset is the integrator's responsibility.

Verification
REQ-029 REQ_NUM=4, reset, ch_rdy=1, req_req=4'b0100 held -> cycle+1: ch_req=1, req_rdy=4'b0100, sel_idx=2, busy=1; next: WAIT, ptr=3.
REQ-030 req_req=4'b1111 held, ch_rdy=1 except low on the cycle after each transfer -> grant order 0,1,2,3,0; sel_idx follows; one req_rdy bit high per transfer.
REQ-031 GRANT to idx 1 with ch_rdy=0 for 5 cycles, then 1 -> ch_req held 5 cycles, sel_idx=1 stable, single transfer on cycle 6.
REQ-032 GRANT to idx 3, requester drops req_req[3] before ch_rdy -> next state IDLE, no transfer, ptr unchanged, next winner from unchanged ptr.
REQ-033 In WAIT with ch_rdy=0 for 10 cycles -> ch_req=0, req_rdy=0, busy=1 throughout; IDLE one cycle after ch_rdy rises.
REQ-034 reset pulsed in GRANT -> next cycle state IDLE, all outputs 0, ptr=0, sel_idx=0.

Source files
------------

// File: rtl/handshake_arbiter.sv
// handshake_arbiter
//   Round-robin arbiter that lets REQ_NUM requesters share one req/rdy
//   handshake channel. Each grant allows one transfer. After the transfer
//   the FSM waits for the channel to show ready again before it arbitrates
//   the next winner.
//
// Ports
//   clk      : single clock, rising edge
//   reset    : synchronous, active-high
//   req_req  : per-requester request (bit i = requester i)
//   req_rdy  : per-requester ready; only the granted bit can be high
//   ch_req   : request to the shared channel
//   ch_rdy   : ready from the shared channel
//   sel_idx  : granted requester index, used to steer payload muxes
//   busy     : high whenever the FSM is not in IDLE
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no grant; pick a winner once the channel is ready
// GRANT | requester gnt owns the channel; one transfer at most
// WAIT  | transfer done; hold off until ch_rdy shows the channel free

module handshake_arbiter #(
  parameter  int REQ_NUM = 4,
  localparam int IW      = $clog2(REQ_NUM)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [REQ_NUM-1:0] req_req,
  output logic [REQ_NUM-1:0] req_rdy,
  output logic               ch_req,
  input  logic               ch_rdy,
  output logic [IW-1:0]      sel_idx,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;

  logic            win_vld;
  logic [IW-1:0]   win_idx;
  int              sum;

  // Rotating priority search starting at ptr_q. The loop runs from the
  // farthest offset down to offset 0 so the nearest requester is the last
  // one written and therefore wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    sum     = 0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      sum = int'(ptr_q) + i;
      if (sum >= REQ_NUM) sum = sum - REQ_NUM;
      if (req_req[sum[IW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    ch_req  = 1'b0;
    req_rdy = '0;
    case (state_q)
      IDLE: begin
        if (win_vld && ch_rdy) begin
          gnt_d   = win_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        ch_req         = req_req[gnt_q];
        req_rdy[gnt_q] = ch_rdy;
        if (!req_req[gnt_q]) begin
          // requester withdrew: give up the grant without moving the pointer
          state_d = IDLE;
        end else if (ch_rdy) begin
          state_d = WAIT;
          ptr_d   = (gnt_q == IW'(REQ_NUM - 1)) ? '0 : gnt_q + IW'(1);
        end
      end
      WAIT: begin
        if (ch_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  assign sel_idx = gnt_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_handshake_arbiter.sv
// Directed bench for handshake_arbiter with REQ_NUM=4. Inputs change on the
// falling edge; outputs are sampled 1 time unit later, so each drive()
// call shows the outputs of the state entered at the preceding rising edge.

module tb_handshake_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req_req;
  logic [3:0] req_rdy;
  logic       ch_req;
  logic       ch_rdy;
  logic [1:0] sel_idx;
  logic       busy;

  int checks = 0;
  int errors = 0;

  handshake_arbiter #(.REQ_NUM(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req_req (req_req),
    .req_rdy (req_rdy),
    .ch_req  (ch_req),
    .ch_rdy  (ch_rdy),
    .sel_idx (sel_idx),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic outs(input string tag, input logic cr, input logic [3:0] rr,
                      input logic [1:0] si, input logic bz);
    check({tag, ".ch_req"},  32'(ch_req),  32'(cr));
    check({tag, ".req_rdy"}, 32'(req_rdy), 32'(rr));
    check({tag, ".sel_idx"}, 32'(sel_idx), 32'(si));
    check({tag, ".busy"},    32'(busy),    32'(bz));
  endtask

  task automatic drive(input logic rst, input logic [3:0] r, input logic c);
    @(negedge clk);
    reset   = rst;
    req_req = r;
    ch_rdy  = c;
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    req_req = 4'b0000;
    ch_rdy  = 1'b0;

    // reset values
    drive(1'b1, 4'b0000, 1'b0);
    outs("rst_during", 1'b0, 4'b0000, 2'd0, 1'b0);
    drive(1'b0, 4'b0000, 1'b1);
    outs("rst_after", 1'b0, 4'b0000, 2'd0, 1'b0);

    // single requester 2, latency one cycle
    drive(1'b0, 4'b0100, 1'b1);
    outs("a_idle", 1'b0, 4'b0000, 2'd0, 1'b0);
    drive(1'b0, 4'b0100, 1'b1);
    outs("a_grant", 1'b1, 4'b0100, 2'd2, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
    outs("a_wait", 1'b0, 4'b0000, 2'd2, 1'b1);
    // ptr now 3: with all requesting, 3 must win
    drive(1'b0, 4'b1111, 1'b1);
    outs("a_idle2", 1'b0, 4'b0000, 2'd2, 1'b0);
    drive(1'b0, 4'b0000, 1'b0);
    outs("a_ptr3_withdraw", 1'b0, 4'b0000, 2'd3, 1'b1);

    // reset, then all four requesting: order 0,1,2,3,0
    drive(1'b1, 4'b0000, 1'b0);
    drive(1'b0, 4'b0000, 1'b1);
    outs("b_rst", 1'b0, 4'b0000, 2'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      logic [1:0] g, p;
      g = 2'(k % 4);
      p = (k == 0) ? 2'd0 : 2'((k + 3) % 4);
      drive(1'b0, 4'b1111, 1'b1);
      outs($sformatf("b%0d_idle", k), 1'b0, 4'b0000, p, 1'b0);
      drive(1'b0, 4'b1111, 1'b1);
      outs($sformatf("b%0d_grant", k), 1'b1, 4'b0001 << g, g, 1'b1);
      drive(1'b0, 4'b1111, 1'b0);
      outs($sformatf("b%0d_wait0", k), 1'b0, 4'b0000, g, 1'b1);
      drive(1'b0, 4'b1111, 1'b1);
      outs($sformatf("b%0d_wait1", k), 1'b0, 4'b0000, g, 1'b1);
    end

    // grant to 1 (ptr=1), channel stalls 5 cycles
    drive(1'b0, 4'b0010, 1'b1);
    outs("c_idle", 1'b0, 4'b0000, 2'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 4'b0010, 1'b0);
      outs($sformatf("c_stall%0d", k), 1'b1, 4'b0000, 2'd1, 1'b1);
    end
    drive(1'b0, 4'b0010, 1'b1);
    outs("c_xfer", 1'b1, 4'b0010, 2'd1, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
    outs("c_wait", 1'b0, 4'b0000, 2'd1, 1'b1);

    // grant to 2 (ptr=2), then WAIT held 10 cycles with other requests ignored
    drive(1'b0, 4'b0100, 1'b1);
    outs("d_idle", 1'b0, 4'b0000, 2'd1, 1'b0);
    drive(1'b0, 4'b0100, 1'b1);
    outs("d_grant", 1'b1, 4'b0100, 2'd2, 1'b1);
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 4'b1011, 1'b0);
      outs($sformatf("d_wait%0d", k), 1'b0, 4'b0000, 2'd2, 1'b1);
    end
    drive(1'b0, 4'b1011, 1'b1);
    outs("d_wait_rise", 1'b0, 4'b0000, 2'd2, 1'b1);
    drive(1'b0, 4'b1011, 1'b1);
    outs("d_idle_after", 1'b0, 4'b0000, 2'd2, 1'b0);

    // GRANT to 3 (ptr=3); requester 3 withdraws
    drive(1'b0, 4'b0011, 1'b0);
    outs("e_withdraw", 1'b0, 4'b0000, 2'd3, 1'b1);
    drive(1'b0, 4'b1001, 1'b1);
    outs("e_idle", 1'b0, 4'b0000, 2'd3, 1'b0);
    // ptr unchanged (3) so 3 beats 0; transfer wraps ptr to 0
    drive(1'b0, 4'b1001, 1'b1);
    outs("e_grant3", 1'b1, 4'b1000, 2'd3, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
    outs("e_wait", 1'b0, 4'b0000, 2'd3, 1'b1);
    drive(1'b0, 4'b1010, 1'b1);
    outs("e_idle2", 1'b0, 4'b0000, 2'd3, 1'b0);
    drive(1'b0, 4'b1010, 1'b1);
    outs("e_wrap_grant1", 1'b1, 4'b0010, 2'd1, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
    outs("e_wait2", 1'b0, 4'b0000, 2'd1, 1'b1);
    drive(1'b0, 4'b1010, 1'b1);
    outs("e_idle3", 1'b0, 4'b0000, 2'd1, 1'b0);

    // ptr=2 -> grant 3; reset pulsed while in GRANT
    drive(1'b1, 4'b1010, 1'b0);
    outs("f_grant_rst", 1'b1, 4'b0000, 2'd3, 1'b1);
    drive(1'b0, 4'b1010, 1'b1);
    outs("f_after_rst", 1'b0, 4'b0000, 2'd0, 1'b0);
    drive(1'b0, 4'b1010, 1'b1);
    outs("f_ptr0_grant1", 1'b1, 4'b0010, 2'd1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
